key_move_ctrl: RTL

//  Consumes the one-cycle press pulses from four key_filter instances (left/right/up/down)
//  and moves a game sprite's top-left position on the 640x480 VGA screen.

---
 rtl/key_game_pkg.sv | 19 +
 rtl/axis_step_clamp.sv | 55 +++++
 rtl/key_move_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/key_game_pkg.sv
// Shared constants for the key-driven sprite mover: direction bit indices,
// FSM state encodings and the visible screen size.
package key_game_pkg;

    localparam int DIR_L = 0;
    localparam int DIR_R = 1;
    localparam int DIR_U = 2;
    localparam int DIR_D = 3;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_ARMED  = 3'b010,
        S_UPDATE = 3'b100
    } move_state_t;

endpackage

// File: rtl/axis_step_clamp.sv
// One axis of sprite motion: steps pos toward 0 (dec) or toward MAX (inc),
// clamping at the bound and flagging which direction was clamped.
module axis_step_clamp #(
    parameter int MAX  = 608,
    parameter int STEP = 8
) (
    input  logic [9:0] pos,
    input  logic       dec,
    input  logic       inc,
    output logic [9:0] nxt,
    output logic       hit_dec,
    output logic       hit_inc
);

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] MAX_W  = 11'(MAX);
    localparam logic [9:0]  MAX_P  = 10'(MAX);

    logic [10:0] pos_w;
    logic [10:0] sum;
    logic [10:0] diff;

    assign pos_w = {1'b0, pos};
    assign sum   = pos_w + STEP_W;
    assign diff  = pos_w - STEP_W;

    // Opposing requests cancel; a single request steps or clamps at the bound.
    always_comb begin
        nxt     = pos;
        hit_dec = 1'b0;
        hit_inc = 1'b0;
        case ({dec, inc})
            2'b10: begin
                if (pos_w < STEP_W) begin
                    nxt     = 10'd0;
                    hit_dec = 1'b1;
                end else begin
                    nxt     = diff[9:0];
                end
            end
            2'b01: begin
                if (sum > MAX_W) begin
                    nxt     = MAX_P;
                    hit_inc = 1'b1;
                end else begin
                    nxt     = sum[9:0];
                end
            end
            default: begin
                nxt = pos;
            end
        endcase
    end

endmodule

// File: rtl/key_move_ctrl.sv
// Latches key press pulses as pending moves and applies them to the sprite
// position once per frame, so the position never changes mid-scan.
module key_move_ctrl
    import key_game_pkg::*;
#(
    parameter int H_ACTIVE = SCREEN_W,
    parameter int V_ACTIVE = SCREEN_H,
    parameter int OBJ_W    = 32,
    parameter int OBJ_H    = 32,
    parameter int STEP     = 8,
    parameter int X_INIT   = 304,
    parameter int Y_INIT   = 224
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left_flag,
    input  logic       right_flag,
    input  logic       up_flag,
    input  logic       down_flag,
    input  logic       frame_tick,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [3:0] edge_hit,
    output logic       update_done
);

    move_state_t state;
    logic [3:0]  pend;
    logic [3:0]  mv;
    logic [3:0]  flags;
    logic [9:0]  nxt_x;
    logic [9:0]  nxt_y;
    logic        hit_l;
    logic        hit_r;
    logic        hit_u;
    logic        hit_d;

    assign flags[DIR_L] = left_flag;
    assign flags[DIR_R] = right_flag;
    assign flags[DIR_U] = up_flag;
    assign flags[DIR_D] = down_flag;

    axis_step_clamp #(
        .MAX  (H_ACTIVE - OBJ_W),
        .STEP (STEP)
    ) u_clamp_x (
        .pos     (pos_x),
        .dec     (mv[DIR_L]),
        .inc     (mv[DIR_R]),
        .nxt     (nxt_x),
        .hit_dec (hit_l),
        .hit_inc (hit_r)
    );

    axis_step_clamp #(
        .MAX  (V_ACTIVE - OBJ_H),
        .STEP (STEP)
    ) u_clamp_y (
        .pos     (pos_y),
        .dec     (mv[DIR_U]),
        .inc     (mv[DIR_D]),
        .nxt     (nxt_y),
        .hit_dec (hit_u),
        .hit_inc (hit_d)
    );

    // Move FSM with pending-request latch and registered position/pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pend        <= 4'd0;
            mv          <= 4'd0;
            pos_x       <= 10'(X_INIT);
            pos_y       <= 10'(Y_INIT);
            edge_hit    <= 4'd0;
            update_done <= 1'b0;
        end else begin
            edge_hit    <= 4'd0;
            update_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    pend <= pend | flags;
                    if (flags != 4'd0) begin
                        state <= S_ARMED;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (frame_tick) begin
                        mv    <= pend | flags;
                        pend  <= 4'd0;
                        state <= S_UPDATE;
                    end else begin
                        pend  <= pend | flags;
                        state <= S_ARMED;
                    end
                end
                S_UPDATE: begin
                    // A tick landing here is ignored; new presses wait for the next frame.
                    pos_x                <= nxt_x;
                    pos_y                <= nxt_y;
                    edge_hit[DIR_L]      <= hit_l;
                    edge_hit[DIR_R]      <= hit_r;
                    edge_hit[DIR_U]      <= hit_u;
                    edge_hit[DIR_D]      <= hit_d;
                    update_done          <= 1'b1;
                    mv                   <= 4'd0;
                    pend                 <= pend | flags;
                    if ((pend | flags) != 4'd0) begin
                        state <= S_ARMED;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    pend  <= 4'd0;
                    mv    <= 4'd0;
                end
            endcase
        end
    end

endmodule
